// File: rtl/serial_byte_receiver.sv
// -----------------------------------------------------------------------------
// serial_byte_receiver
//
// Serial-in, parallel-out receiver for a strobed serial line. A frame is:
//   start bit (0), BUS_WIDTH data bits, [even parity bit], stop bit (1).
// The line is sampled only on clk edges where bit_en_i is high. The data bits
// are assembled in a shift register whose direction (dir_i) is latched at the
// start bit:
//   dir = 0 : MSB-first (bit enters at bit 0 and shifts toward the MSB)
//   dir = 1 : LSB-first (bit enters at the MSB and shifts toward bit 0)
//
// A good stop bit copies the shift register to data_o and pulses valid_o.
// A low stop bit pulses frame_err_o and parks the FSM in WAIT_HIGH until the
// line is sampled high again, so a held-low (break) line never starts a frame.
//
// Optional feature (compile-time macro): SERIAL_BYTE_RECEIVER_PARITY_EN
//   Defined   : one even-parity bit follows the data bits; a mismatch pulses
//               parity_err_o at the stop-bit sample and suppresses valid_o.
//   Undefined : no parity bit; parity_err_o is tied low.
// -----------------------------------------------------------------------------
module serial_byte_receiver #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 serial_i,
  input  logic                 bit_en_i,
  input  logic                 dir_i,
  output logic [BUS_WIDTH-1:0] data_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic                 frame_err_o,
  output logic                 parity_err_o
);

  // Counter is wide enough to hold BUS_WIDTH without wrapping inside a frame.
  localparam int                 CNT_W    = $clog2(BUS_WIDTH + 1);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(BUS_WIDTH - 1);

`ifdef SERIAL_BYTE_RECEIVER_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DATA      = 3'd1,
    S_PARITY    = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DATA      = 3'd1,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_e;
`endif

  state_e                 state_q,      state_d;
  logic [BUS_WIDTH-1:0]   shift_q,      shift_d;
  logic [CNT_W-1:0]       cnt_q,        cnt_d;
  logic                   dir_q,        dir_d;
  logic [BUS_WIDTH-1:0]   data_q,       data_d;
  logic                   valid_q,      valid_d;
  logic                   frame_err_q,  frame_err_d;
  logic                   parity_ok;

`ifdef SERIAL_BYTE_RECEIVER_PARITY_EN
  // Running XOR of every data bit and the parity bit; zero means even parity.
  logic                   par_q,        par_d;
  logic                   parity_err_q, parity_err_d;

  assign parity_ok = ~par_q;
`else
  assign parity_ok = 1'b1;
`endif

  // Shift register step for the direction latched at the start bit.
  function automatic logic [BUS_WIDTH-1:0] shift_in(
    input logic [BUS_WIDTH-1:0] cur,
    input logic                 lsb_first,
    input logic                 bit_in
  );
    if (lsb_first) begin
      return {bit_in, cur[BUS_WIDTH-1:1]};
    end
    return {cur[BUS_WIDTH-2:0], bit_in};
  endfunction

  // State, datapath and output registers; everything clears on reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  // NOTE: the shift register is reset alongside the control state so that a
  // mid-frame reset leaves no partial word behind for the next frame.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef SERIAL_BYTE_RECEIVER_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
`ifdef SERIAL_BYTE_RECEIVER_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state and datapath logic; only strobe cycles advance the frame.
  // NOTE: every signal gets a default before the case statement, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    frame_err_d  = 1'b0;
`ifdef SERIAL_BYTE_RECEIVER_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    if (bit_en_i) begin
      unique case (state_q)
        S_IDLE: begin
          if (!serial_i) begin
            dir_d   = dir_i;
            cnt_d   = '0;
            state_d = S_DATA;
`ifdef SERIAL_BYTE_RECEIVER_PARITY_EN
            par_d   = 1'b0;
`endif
          end
        end

        S_DATA: begin
          shift_d = shift_in(shift_q, dir_q, serial_i);
          cnt_d   = cnt_q + 1'b1;
`ifdef SERIAL_BYTE_RECEIVER_PARITY_EN
          par_d   = par_q ^ serial_i;
          if (cnt_q == LAST_BIT) begin
            state_d = S_PARITY;
          end
`else
          if (cnt_q == LAST_BIT) begin
            state_d = S_STOP;
          end
`endif
        end

`ifdef SERIAL_BYTE_RECEIVER_PARITY_EN
        S_PARITY: begin
          par_d   = par_q ^ serial_i;
          state_d = S_STOP;
        end
`endif

        S_STOP: begin
          if (serial_i) begin
            // Good stop bit: publish the word only if parity also checks out.
            if (parity_ok) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HIGH;
          end
`ifdef SERIAL_BYTE_RECEIVER_PARITY_EN
          parity_err_d = ~parity_ok;
`endif
        end

        S_WAIT_HIGH: begin
          // A break holds the line low; only a high sample re-arms the FSM.
          if (serial_i) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output mapping; busy follows the registered state directly.
  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = (state_q != S_IDLE);

`ifdef SERIAL_BYTE_RECEIVER_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_serial_byte_receiver.sv
// -----------------------------------------------------------------------------
// tb_serial_byte_receiver
//
// Table-driven bench for serial_byte_receiver (BUS_WIDTH = 8). Each table row
// holds the inputs for one clock cycle and the outputs expected right after
// that cycle's rising edge. Frames are expanded into rows by add_frame(), with
// the completed word supplied as a hand-computed constant. The asynchronous
// mid-frame reset is exercised by a hand-written sequence.
// Honours SERIAL_BYTE_RECEIVER_PARITY_EN: frames then carry a parity bit.
// -----------------------------------------------------------------------------
module tb_serial_byte_receiver;

  logic       clk      = 1'b0;
  logic       rst_i    = 1'b1;
  logic       serial_i = 1'b1;
  logic       bit_en_i = 1'b0;
  logic       dir_i    = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic       busy_o;
  logic       frame_err_o;
  logic       parity_err_o;

  serial_byte_receiver #(.BUS_WIDTH(8)) dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .serial_i     (serial_i),
    .bit_en_i     (bit_en_i),
    .dir_i        (dir_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .busy_o       (busy_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       ser;
    logic       dir;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       ferr;
    logic       perr;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  // Compare packed {data, valid, busy, frame_err, parity_err}.
  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks_total++;
    if (act === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got data=%h valid=%b busy=%b ferr=%b perr=%b, want data=%h valid=%b busy=%b ferr=%b perr=%b",
               name, act[11:4], act[3], act[2], act[1], act[0],
               exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic add(input logic rst, input logic en, input logic ser, input logic dir,
                     input logic [7:0] data, input logic valid, input logic busy,
                     input logic ferr, input logic perr, input string name);
    vec_t v;
    v.rst = rst; v.en = en; v.ser = ser; v.dir = dir;
    v.data = data; v.valid = valid; v.busy = busy; v.ferr = ferr; v.perr = perr;
    v.name = name;
    vecs.push_back(v);
  endtask

  // Expand one frame into rows. line[7] is the first data bit on the wire.
  // toggle flips dir_i from data bit 3 on; gap inserts a non-strobe cycle;
  // flip corrupts the parity bit (parity builds only).
  task automatic add_frame(input logic [7:0] line, input logic dir, input logic toggle,
                           input logic gap, input logic flip, input logic stop,
                           input logic [7:0] word, input logic [7:0] prev, input string tag);
    logic good;
    logic perr;
    add(1'b0, 1'b1, 1'b0, dir, prev, 1'b0, 1'b1, 1'b0, 1'b0, {tag, " start"});
    for (int i = 0; i < 8; i++) begin
      logic b;
      b = line[7-i];
      add(1'b0, 1'b1, b, dir ^ (toggle && i >= 3), prev, 1'b0, 1'b1, 1'b0, 1'b0,
          $sformatf("%s d%0d", tag, i));
      if (gap && i == 3) begin
        add(1'b0, 1'b0, ~b, ~dir, prev, 1'b0, 1'b1, 1'b0, 1'b0, {tag, " gap"});
      end
    end
`ifdef SERIAL_BYTE_RECEIVER_PARITY_EN
    add(1'b0, 1'b1, (^line) ^ flip, dir, prev, 1'b0, 1'b1, 1'b0, 1'b0, {tag, " parity"});
    perr = flip;
`else
    perr = 1'b0;
`endif
    good = stop && !perr;
    add(1'b0, 1'b1, stop, dir, good ? word : prev, good, !stop, !stop, perr, {tag, " stop"});
  endtask

  // Apply each row, sample 1 time unit after the rising edge, then clear.
  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) begin
      rst_i    = vecs[i].rst;
      bit_en_i = vecs[i].en;
      serial_i = vecs[i].ser;
      dir_i    = vecs[i].dir;
      @(posedge clk);
      #1;
      check(vecs[i].name,
            {data_o, valid_o, busy_o, frame_err_o, parity_err_o},
            {vecs[i].data, vecs[i].valid, vecs[i].busy, vecs[i].ferr, vecs[i].perr});
    end
    vecs.delete();
  endtask

  initial begin
    logic [4:0] partial;

    // Phase A: reset, idle line, both directions, framing error with break.
    add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "reset 0");
    add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "reset 1");
    for (int i = 0; i < 5; i++) begin
      add(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("idle high %0d", i));
    end
    add_frame(8'hB2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hB2, 8'h00, "msb");
    add_frame(8'hB2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h4D, 8'hB2, "lsb");
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h4D, 1'b0, 1'b0, 1'b0, 1'b0, "pulse clears");
    add_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h4D, "ferr");
    for (int i = 0; i < 4; i++) begin
      add(1'b0, 1'b1, 1'b0, 1'b0, 8'h4D, 1'b0, 1'b1, 1'b0, 1'b0, $sformatf("break low %0d", i));
    end
    add(1'b0, 1'b1, 1'b1, 1'b0, 8'h4D, 1'b0, 1'b0, 1'b0, 1'b0, "line high");
    add(1'b0, 1'b1, 1'b1, 1'b0, 8'h4D, 1'b0, 1'b0, 1'b0, 1'b0, "idle after break");
    run_table();

    // Hand-written: start bit plus 4 data bits, then async reset mid-cycle.
    partial = 5'b01011;
    for (int i = 4; i >= 0; i--) begin
      bit_en_i = 1'b1;
      serial_i = partial[i];
      dir_i    = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("partial %0d", 4 - i),
            {data_o, valid_o, busy_o, frame_err_o, parity_err_o},
            {8'h4D, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    #2;
    rst_i = 1'b1;
    #1;
    check("async reset", {data_o, valid_o, busy_o, frame_err_o, parity_err_o}, 12'h000);
    @(posedge clk);
    #1;
    check("reset held", {data_o, valid_o, busy_o, frame_err_o, parity_err_o}, 12'h000);
    rst_i    = 1'b0;
    serial_i = 1'b1;

    // Phase B: a full frame after the mid-frame reset.
    add_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 8'h00, "after reset");
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, "idle after 3C");
    run_table();

`ifdef SERIAL_BYTE_RECEIVER_PARITY_EN
    // Phase C: good parity, then a corrupted parity bit.
    add_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0F, 8'h3C, "par ok");
    add_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0F, 8'h0F, "par bad");
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, "idle after par");
    run_table();
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
